mem_dma: RTL and testbench

- Memory-side initiator for the 8-bit CPU's synchronous single-port RAM; the RAM is the responder.
- Drives the RAM's write-enable, address and write-data inputs, and consumes its registered read data.
- Performs block copy (src -> dst) or block fill (constant -> dst) of up to 256 bytes on a single start pulse.
- Sits beside the CPU datapath; memory-port arbitration with the CPU is external.

---
 rtl/mem_dma_if.sv | 24 ++
 rtl/mem_dma.sv | 144 ++++++++++++++
 tb/tb_mem_dma.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_if.sv
// Memory-port bundle between the DMA initiator (master) and the single-port RAM (slave).
interface mem_dma_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_dma.sv
// Block copy/fill engine driving a synchronous single-port RAM.
// Optional MEM_DMA_CHECKSUM_EN adds a running byte-sum of the bytes written.
module mem_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  mem_dma_if.master         mem
`ifdef MEM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_fill_val;

  logic [LEN_W-1:0]  w_len_clamped;
  logic              w_last;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_accept;

  assign w_len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign w_last        = (r_remaining == LEN_W'(1));
  assign w_accept      = (r_state == S_IDLE) && start;

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_clamped == '0) w_next_state = S_DONE;
          else if (mode)           w_next_state = S_FILL;
          else                     w_next_state = S_RD;
        end
      end
      S_RD: begin
        busy         = 1'b1;
        w_addr       = r_src_ptr;
        w_next_state = abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        busy    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_dst_ptr;
        w_wdata = mem.mem_rdata;
        if (abort)       w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_DONE;
        else             w_next_state = S_RD;
      end
      S_FILL: begin
        busy    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_dst_ptr;
        w_wdata = r_fill_val;
        if (abort)       w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign mem.mem_we    = w_we;
  assign mem.mem_addr  = w_addr;
  assign mem.mem_wdata = w_wdata;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_fill_val  <= '0;
    end else if (w_accept) begin
      r_src_ptr   <= src_addr;
      r_dst_ptr   <= dst_addr;
      r_remaining <= w_len_clamped;
      r_fill_val  <= fill_val;
    end else if (r_state == S_WR) begin
      r_src_ptr   <= r_src_ptr + 1'b1;
      r_dst_ptr   <= r_dst_ptr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end else if (r_state == S_FILL) begin
      r_dst_ptr   <= r_dst_ptr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

`ifdef MEM_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Includes the byte written in an aborted cycle, since that write still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_checksum <= '0;
    else if (w_accept)                            r_checksum <= '0;
    else if (r_state == S_WR || r_state == S_FILL) r_checksum <= r_checksum + w_wdata;
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_dma.sv
// Directed self-checking bench for mem_dma with a behavioural synchronous RAM.
module tb_mem_dma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [8:0] len = '0;
  logic [7:0] fill_val = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
`ifdef MEM_DMA_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] ram [256];

  mem_dma_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_dma #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .fill_val (fill_val),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .mem      (bus.master)
`ifdef MEM_DMA_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write on we, registered read of the presented address.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic m, input logic [7:0] s, input logic [7:0] d,
                             input logic [8:0] l, input logic [7:0] fv);
    @(posedge clk);
    #1;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = fv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Watches n cycles after the start edge; optionally pulses a stray start at cycle restart_at.
  task automatic run_watch(input int n, input int restart_at,
                           output int busy_n, output int done_at, output int done_n,
                           output int we_n, output logic [31:0] addr_seq);
    busy_n = 0; done_at = 0; done_n = 0; we_n = 0; addr_seq = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (bus.mem_we) begin
        we_n++;
        addr_seq = {addr_seq[23:0], bus.mem_addr};
      end
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (k == restart_at) begin
        start = 1'b1; mode = 1'b1; dst_addr = 8'hC0; len = 9'd2; fill_val = 8'h11;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  int          busy_n, done_at, done_n, we_n;
  logic [31:0] addr_seq;
  logic [7:0]  src_bytes [4];
  logic [7:0]  sum;

  initial begin
    src_bytes[0] = 8'hA1; src_bytes[1] = 8'hB2; src_bytes[2] = 8'hC3; src_bytes[3] = 8'hD4;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    for (int i = 0; i < 4; i++) ram[8'h10 + i] = src_bytes[i];
    ram[8'h23] = 8'hEE;

    #12;
    check("rst_busy",  {31'd0, busy},        32'd0);
    check("rst_done",  {31'd0, done},        32'd0);
    check("rst_we",    {31'd0, bus.mem_we},  32'd0);
    check("rst_addr",  {24'd0, bus.mem_addr},  32'd0);
    check("rst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Copy 4 bytes 0x10 -> 0x80.
    pulse_start(1'b0, 8'h10, 8'h80, 9'd4, 8'h00);
    run_watch(12, 0, busy_n, done_at, done_n, we_n, addr_seq);
    check("copy_busy",    busy_n,  8);
    check("copy_done_at", done_at, 9);
    check("copy_done_n",  done_n,  1);
    check("copy_addrs",   addr_seq, 32'h80818283);
    sum = 8'h00;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("copy_ram%0d", i), {24'd0, ram[8'h80 + i]}, {24'd0, src_bytes[i]});
      sum = sum + src_bytes[i];
    end
`ifdef MEM_DMA_CHECKSUM_EN
    check("copy_csum", {24'd0, checksum}, {24'd0, sum});
`endif

    // Fill across the address wrap.
    pulse_start(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A);
    run_watch(8, 0, busy_n, done_at, done_n, we_n, addr_seq);
    check("fill_busy",    busy_n,  4);
    check("fill_done_at", done_at, 5);
    check("fill_addrs",   addr_seq, 32'hFEFF0001);
    check("fill_ramFE", {24'd0, ram[8'hFE]}, 32'h5A);
    check("fill_ramFF", {24'd0, ram[8'hFF]}, 32'h5A);
    check("fill_ram00", {24'd0, ram[8'h00]}, 32'h5A);
    check("fill_ram01", {24'd0, ram[8'h01]}, 32'h5A);
    check("fill_ram02", {24'd0, ram[8'h02]}, 32'h00);

    // Zero length.
    pulse_start(1'b0, 8'h10, 8'h60, 9'd0, 8'h00);
    run_watch(4, 0, busy_n, done_at, done_n, we_n, addr_seq);
    check("zero_done_at", done_at, 1);
    check("zero_done_n",  done_n,  1);
    check("zero_we",      we_n,    0);
    check("zero_busy",    busy_n,  0);

    // Abort during the third FILL cycle.
    pulse_start(1'b1, 8'h00, 8'h20, 9'd10, 8'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy},       32'd0);
    check("abort_we",   {31'd0, bus.mem_we}, 32'd0);
    run_watch(6, 0, busy_n, done_at, done_n, we_n, addr_seq);
    check("abort_no_done", done_n, 0);
    check("abort_ram20", {24'd0, ram[8'h20]}, 32'h77);
    check("abort_ram22", {24'd0, ram[8'h22]}, 32'h77);
    check("abort_ram23", {24'd0, ram[8'h23]}, 32'hEE);
`ifdef MEM_DMA_CHECKSUM_EN
    check("abort_csum", {24'd0, checksum}, 32'h65);
`endif
    pulse_start(1'b1, 8'h00, 8'h40, 9'd1, 8'h42);
    run_watch(4, 0, busy_n, done_at, done_n, we_n, addr_seq);
    check("after_abort_done_at", done_at, 2);
    check("after_abort_ram40", {24'd0, ram[8'h40]}, 32'h42);

    // Second start during a copy is ignored.
    pulse_start(1'b0, 8'h10, 8'h90, 9'd4, 8'h00);
    run_watch(14, 3, busy_n, done_at, done_n, we_n, addr_seq);
    check("busy_start_done_at", done_at, 9);
    check("busy_start_done_n",  done_n,  1);
    check("busy_start_we",      we_n,    4);
    check("busy_start_ram93", {24'd0, ram[8'h93]}, 32'hD4);
    check("busy_start_ramC0", {24'd0, ram[8'hC0]}, 32'h00);

    // Reset during WR.
    pulse_start(1'b0, 8'h10, 8'hA0, 9'd4, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_we", {31'd0, bus.mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we",   {31'd0, bus.mem_we}, 32'd0);
    check("rst_mid_busy", {31'd0, busy},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(1'b1, 8'h00, 8'h50, 9'd2, 8'h99);
    run_watch(5, 0, busy_n, done_at, done_n, we_n, addr_seq);
    check("post_rst_done_at", done_at, 3);
    check("post_rst_ram51", {24'd0, ram[8'h51]}, 32'h99);

    // Oversized length clamps to 256.
    pulse_start(1'b1, 8'h00, 8'h00, 9'd300, 8'h3C);
    run_watch(262, 0, busy_n, done_at, done_n, we_n, addr_seq);
    check("clamp_busy",    busy_n,  256);
    check("clamp_done_at", done_at, 257);
    check("clamp_we",      we_n,    256);
    check("clamp_ram10", {24'd0, ram[8'h10]}, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
